// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
// Time-multiplexes a bank of common-anode seven-segment digits through one
// shared segment decoder. Each digit slot is a BLANK gap (all anodes off)
// followed by a SHOW period with one anode driven low.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken digits above digit 0
// whose value and all higher digit values are zero.

module display_scan_scheduler #(
    parameter int unsigned CLK_DIV      = 104166,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DIGIT_W      = 4
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] values,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [DIGIT_W-1:0]            seg_value,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int unsigned MAX_DWELL = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W     = $clog2(MAX_DWELL + 1);
    localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [DIGIT_W-1:0]      seg_q, seg_d;
    logic                    tick_q, tick_d;
    logic [NUM_DIGITS-1:0]   visible;

    // Per-digit visibility decided at SHOW entry.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        visible = digit_mask;
        for (int i = 1; i < int'(NUM_DIGITS); i++) begin
            // Shifting down leaves only slices i..NUM_DIGITS-1 to test for zero.
            if ((values >> (i * int'(DIGIT_W))) == '0) begin
                visible[i] = 1'b0;
            end
        end
    end
`else
    always_comb begin
        visible = digit_mask;
    end
`endif

    // Next-state and registered-output logic for the scan FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        anode_d = anode_q;
        seg_d   = seg_q;
        tick_d  = 1'b0;

        if (!enable) begin
            // Going dark: seg_value intentionally keeps its last value.
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            anode_d = ANODE_OFF;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    anode_d = ANODE_OFF;
                end
                ST_BLANK: begin
                    anode_d = ANODE_OFF;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        seg_d   = values[int'(idx_q)*int'(DIGIT_W) +: DIGIT_W];
                        // A masked digit still consumes its slot; only the anode stays off.
                        anode_d = visible[idx_q] ? ~(NUM_DIGITS'(1) << idx_q) : ANODE_OFF;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        anode_d = ANODE_OFF;
                        tick_d  = (idx_q == IDX_LAST);
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    anode_d = ANODE_OFF;
                end
            endcase
        end
    end

    // State and output registers; reset turns every anode off without a clock.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            anode_q <= ANODE_OFF;
            seg_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign anode      = anode_q;
    assign seg_value  = seg_q;
    assign digit_idx  = idx_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Testbench for display_scan_scheduler (CLK_DIV=4, BLANK_CYCLES=2, NUM_DIGITS=4).
// Reference model: the scan position is a single phase count since the first
// BLANK cycle; slot and offset follow from division by the slot length.

module tb_display_scan_scheduler;

    localparam int CLK_DIV = 4;
    localparam int BLANK   = 2;
    localparam int N       = 4;
    localparam int W       = 4;
    localparam int SLOT    = BLANK + CLK_DIV;
    localparam int FRAME   = N * SLOT;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [N-1:0]     digit_mask;
    logic [N*W-1:0]   values;
    logic [N-1:0]     anode;
    logic [W-1:0]     seg_value;
    logic [1:0]       digit_idx;
    logic             frame_tick;

    display_scan_scheduler #(
        .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK), .NUM_DIGITS(N), .DIGIT_W(W)
    ) dut (
        .clk_in(clk), .reset(reset), .enable(enable), .digit_mask(digit_mask),
        .values(values), .anode(anode), .seg_value(seg_value),
        .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state
    bit         m_run;
    int         m_p;
    logic [3:0] m_anode;
    logic [3:0] m_seg;
    int         m_idx;
    bit         m_ft;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_p = 0; m_anode = 4'hF; m_seg = 4'h0; m_idx = 0; m_ft = 0;
    endtask

    // Predicts outputs after a rising edge from the inputs seen at that edge.
    task automatic model_step();
        int off, slot;
        bit vis;
        if (!enable) begin
            m_run = 0; m_p = 0; m_anode = 4'hF; m_idx = 0; m_ft = 0;
        end else if (!m_run) begin
            m_run = 1; m_p = 0; m_anode = 4'hF; m_idx = 0; m_ft = 0;
        end else begin
            m_p++;
            off   = m_p % SLOT;
            slot  = (m_p / SLOT) % N;
            m_idx = slot;
            m_ft  = (off == 0) && (slot == 0);
            if (off < BLANK) begin
                m_anode = 4'hF;
            end else if (off == BLANK) begin
                m_seg = values[slot*W +: W];
                vis   = digit_mask[slot];
`ifdef LEADING_ZERO_BLANK_EN
                if (slot > 0 && (values >> (slot * W)) == 0) vis = 0;
`endif
                m_anode = vis ? ~(4'b0001 << slot) : 4'hF;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Cycle-by-cycle comparison against the model, plus structural properties.
    int cyc = 0;
    int last_tick = -1;
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("anode", anode, m_anode);
            check("seg_value", seg_value, m_seg);
            check("digit_idx", digit_idx, m_idx);
            check("frame_tick", frame_tick, m_ft);
            check("anode_one_low", ($countones(~anode) <= 1), 1);
            if (!enable || !reset) begin
                last_tick = -1;
            end else if (frame_tick === 1'b1) begin
                if (last_tick >= 0) check("frame_period", cyc - last_tick, FRAME);
                last_tick = cyc;
            end
        end
    end

    initial begin
        reset = 1'b0; enable = 1'b0; digit_mask = '0; values = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // Idle with enable low
        repeat (20) step();
        check("idle_anode", anode, 4'hF);
        check("idle_idx", digit_idx, 0);

        // Scan order with all digits visible
        digit_mask = 4'b1111; values = 16'h4321; enable = 1'b1;
        repeat (3) step();
        check("d0_anode", anode, 4'b1110);
        check("d0_seg", seg_value, 4'h1);
        repeat (6) step();
        check("d1_anode", anode, 4'b1101);
        check("d1_seg", seg_value, 4'h2);
        repeat (6) step();
        check("d2_anode", anode, 4'b1011);
        check("d2_seg", seg_value, 4'h3);
        repeat (6) step();
        check("d3_anode", anode, 4'b0111);
        check("d3_seg", seg_value, 4'h4);
        repeat (4) step();
        check("frame_tick_lit", frame_tick, 1'b1);
        check("wrap_idx", digit_idx, 0);

        // Masked digits keep their slots dark
        digit_mask = 4'b0101;
        repeat (2) step();
        check("mask_d0", anode, 4'b1110);
        repeat (6) step();
        check("mask_d1_dark", anode, 4'hF);
        check("mask_d1_idx", digit_idx, 1);

        // Value hold across a mid-digit change
        enable = 1'b0; step();
        enable = 1'b1; digit_mask = 4'b1111; values = 16'h4321;
        repeat (4) step();
        values = 16'hFFFF;
        repeat (2) step();
        check("hold_seg", seg_value, 4'h1);
        repeat (3) step();
        check("next_seg", seg_value, 4'hF);
        check("next_anode", anode, 4'b1101);

        // Disable during digit 2, then restart from digit 0
        repeat (6) step();
        check("pre_dis_anode", anode, 4'b1011);
        enable = 1'b0; step();
        check("dis_anode", anode, 4'hF);
        check("dis_idx", digit_idx, 0);
        enable = 1'b1;
        repeat (2) step();
        check("reen_blank", anode, 4'hF);
        step();
        check("reen_d0", anode, 4'b1110);

        // Leading-zero pattern
        values = 16'h0050;
        repeat (6) step();
        check("lz_d1_seg", seg_value, 4'h5);
        check("lz_d1_anode", anode, 4'b1101);
        repeat (6) step();
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_d2_anode", anode, 4'hF);
`else
        check("lz_d2_anode", anode, 4'b1011);
`endif
        repeat (6) step();
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_d3_anode", anode, 4'hF);
`else
        check("lz_d3_anode", anode, 4'b0111);
`endif
        repeat (6) step();
        check("lz_d0_seg", seg_value, 4'h0);
        check("lz_d0_anode", anode, 4'b1110);

        // Randomized traffic
        repeat (3000) begin
            int r;
            step();
            r = $urandom_range(0, 199);
            if (r < 50) values = $urandom;
            if (r < 15) digit_mask = $urandom;
            if (r == 100) enable = ~enable;
            if (r == 101 && !enable) enable = 1'b1;
        end

        // Asynchronous reset during SHOW
        digit_mask = 4'b1111; enable = 1'b1;
        begin
            int budget = 40;
            while (m_anode == 4'hF && budget > 0) begin
                step();
                budget--;
            end
            check("show_reached", (budget > 0), 1);
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("async_anode", anode, 4'hF);
        check("async_idx", digit_idx, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
